// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states, next-PC select codes, PC width.
package fetch_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } fetchState_e;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_JMP  = 2'd2,
        SEL_HOLD = 2'd3
    } pcSel_e;

    // Word-align a redirect target by clearing the byte offset.
    function automatic logic [PC_W-1:0] alignPc(input logic [PC_W-1:0] target);
        alignPc = {target[PC_W-1:2], 2'b00};
    endfunction

    function automatic logic isMisaligned(input logic [PC_W-1:0] target);
        isMisaligned = (target[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_next_pc_sel.sv
// Next-PC priority mux: taken branch > jump > halt detect > stall > sequential, with target word alignment.
module fetch_next_pc_sel
    import fetch_pkg::*;
#(
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  fetchState_e     state,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] pcPlus4,
    input  logic [31:0]     instr,
    input  logic            stallReq,
    input  logic            takeBr,
    input  logic            jump,
    input  logic [PC_W-1:0] branchTarget,
    input  logic [PC_W-1:0] jumpTarget,
    output pcSel_e          sel,
    output logic [PC_W-1:0] nextPc,
    output logic            misalign
);

    // Pick the PC source; once halted only an older taken branch can restart fetch.
    always_comb begin
        sel      = SEL_SEQ;
        nextPc   = pcPlus4;
        misalign = 1'b0;
        if (state == HALT) begin
            if (takeBr) begin
                sel = SEL_BR;
            end else begin
                sel = SEL_HOLD;
            end
        end else if (takeBr) begin
            sel = SEL_BR;
        end else if (jump) begin
            sel = SEL_JMP;
        end else if (instr == HALT_WORD) begin
            sel = SEL_HOLD;
        end else if (stallReq) begin
            sel = SEL_HOLD;
        end else begin
            sel = SEL_SEQ;
        end

        case (sel)
            SEL_BR: begin
                nextPc   = alignPc(branchTarget);
                misalign = isMisaligned(branchTarget);
            end
            SEL_JMP: begin
                nextPc   = alignPc(jumpTarget);
                misalign = isMisaligned(jumpTarget);
            end
            SEL_HOLD: nextPc = pc;
            SEL_SEQ:  nextPc = pcPlus4;
            default:  nextPc = pcPlus4;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC register, RUN/STALL/HALT FSM, flush strobes and sticky error flags.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]     HALT_WORD = 32'hFFFF_FFFF,
    parameter int              MAX_STALL = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic            stall_req,
    input  logic            branch,
    input  logic            zero_alu,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            halted,
    output logic            stall_timeout,
    output logic            misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     redirect_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);

    fetchState_e     state_r, nextState_s;
    pcSel_e          sel_s;
    logic [PC_W-1:0] pc_r, pcPlus4_s, nextPc_s;
    logic            redirMisalign_s, takeBr_s, haltDet_s, ifidWrite_s, stallHold_s;
    logic [7:0]      stallCnt_r, nextStallCnt_s;
    logic            halted_r, stallTimeout_r, misalignErr_r;

    assign takeBr_s  = branch & zero_alu;
    assign haltDet_s = (instr == HALT_WORD);
    assign pcPlus4_s = pc_r + 32'd4;

    fetch_next_pc_sel #(.HALT_WORD(HALT_WORD)) u_sel (
        .state        (state_r),
        .pc           (pc_r),
        .pcPlus4      (pcPlus4_s),
        .instr        (instr),
        .stallReq     (stall_req),
        .takeBr       (takeBr_s),
        .jump         (jump),
        .branchTarget (branch_target),
        .jumpTarget   (jump_target),
        .sel          (sel_s),
        .nextPc       (nextPc_s),
        .misalign     (redirMisalign_s)
    );

    // Next FSM state and IF/ID load enable from the selected PC source.
    always_comb begin
        nextState_s = state_r;
        ifidWrite_s = 1'b1;
        stallHold_s = 1'b0;
        case (state_r)
            HALT: begin
                if (sel_s == SEL_BR) begin
                    nextState_s = RUN;
                end else begin
                    nextState_s = HALT;
                    ifidWrite_s = 1'b0;
                end
            end
            RUN, STALL: begin
                case (sel_s)
                    SEL_BR, SEL_JMP: nextState_s = RUN;
                    SEL_HOLD: begin
                        if (haltDet_s) begin
                            nextState_s = HALT;
                        end else begin
                            nextState_s = STALL;
                            ifidWrite_s = 1'b0;
                            stallHold_s = 1'b1;
                        end
                    end
                    SEL_SEQ: nextState_s = RUN;
                    default: nextState_s = RUN;
                endcase
            end
            default: nextState_s = RUN;
        endcase
    end

    // Consecutive-stall counter, saturating so the timeout cannot be missed by wrap-around.
    always_comb begin
        if (!stall_req) begin
            nextStallCnt_s = 8'd0;
        end else if ((state_r == STALL) && (stallCnt_r != 8'hFF)) begin
            nextStallCnt_s = stallCnt_r + 8'd1;
        end else begin
            nextStallCnt_s = stallCnt_r;
        end
    end

    // PC, FSM state and sticky status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r           <= RESET_PC;
            state_r        <= RUN;
            stallCnt_r     <= 8'd0;
            halted_r       <= 1'b0;
            stallTimeout_r <= 1'b0;
            misalignErr_r  <= 1'b0;
        end else begin
            pc_r       <= nextPc_s;
            state_r    <= nextState_s;
            stallCnt_r <= nextStallCnt_s;
            halted_r   <= (nextState_s == HALT);
            if (nextStallCnt_s == MAX_STALL_C) begin
                stallTimeout_r <= 1'b1;
            end
            if (redirMisalign_s) begin
                misalignErr_r <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCnt_r, redirectCnt_r, stallCnt32_r;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchCnt_r    <= 32'd0;
            redirectCnt_r <= 32'd0;
            stallCnt32_r  <= 32'd0;
        end else begin
            if (sel_s == SEL_SEQ) begin
                fetchCnt_r <= fetchCnt_r + 32'd1;
            end
            if ((sel_s == SEL_BR) || (sel_s == SEL_JMP)) begin
                redirectCnt_r <= redirectCnt_r + 32'd1;
            end
            if (stallHold_s) begin
                stallCnt32_r <= stallCnt32_r + 32'd1;
            end
        end
    end

    assign fetch_cnt    = fetchCnt_r;
    assign redirect_cnt = redirectCnt_r;
    assign stall_cnt    = stallCnt32_r;
`endif

    assign pc            = pc_r;
    assign pc_plus4      = pcPlus4_s;
    assign ifid_write    = ifidWrite_s;
    assign ifid_flush    = takeBr_s | jump;
    assign idex_flush    = takeBr_s;
    assign halted        = halted_r;
    assign stall_timeout = stallTimeout_r;
    assign misalign_err  = misalignErr_r;

endmodule
